// File: rtl/sonic_irq_coalescer.sv
`timescale 1ns/1ps
// Multi-channel RX interrupt moderator: tracks per-channel ring pointers, fires on byte
// threshold or idle timeout, round-robins one channel per status update plus optional MSI.
module sonic_irq_coalescer #(
  parameter int NUM_CHAN    = 2,
  parameter int PTR_WIDTH   = 13,
  parameter int TIMER_WIDTH = 16,
  parameter bit USE_MSI     = 1'b1,
  localparam int CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                          clk_in,
  input  logic                          rstn,
  input  logic                          init,
  input  logic                          irq_enable,
  input  logic [NUM_CHAN-1:0]           chan_enable,
  input  logic [PTR_WIDTH-1:0]          rx_ring_size,
  input  logic [PTR_WIDTH-1:0]          rx_block_size,
  input  logic [TIMER_WIDTH-1:0]        irq_timeout,
  input  logic [NUM_CHAN*PTR_WIDTH-1:0] rx_ring_wptr,
  output logic                          upd_req,
  input  logic                          upd_ack,
  output logic [CHAN_W-1:0]             upd_chan,
  output logic [PTR_WIDTH-1:0]          upd_bytes,
  output logic                          msi_ready,
  input  logic                          msi_sel,
  output logic                          app_msi_req,
  input  logic                          app_msi_ack,
  output logic [4:0]                    app_msi_num,
  output logic [NUM_CHAN-1:0]           irq_pending
);

  typedef enum logic [1:0] {ST_IDLE, ST_UPD, ST_MSI_WAIT, ST_MSI_REQ} state_t;

  state_t                             r_state, w_next;
  logic                               r_upd_req, r_msi_ready, r_app_msi_req;
  logic [CHAN_W-1:0]                  r_upd_chan, r_rr_ptr, w_grant_chan, w_rr_next;
  logic [PTR_WIDTH-1:0]               r_upd_bytes;
  logic [NUM_CHAN-1:0][PTR_WIDTH-1:0] w_pend;
  logic [NUM_CHAN-1:0]                w_trig, w_req, r_irq_pending;
  logic                               w_grant_valid, w_take, w_ack;

  assign w_ack = (r_state == ST_UPD) && upd_ack;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    logic [PTR_WIDTH-1:0]   w_wptr, w_raw, w_adv, r_msi_ptr;
    logic [PTR_WIDTH:0]     w_sum;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   w_ack_here, w_idle_hit;

    // The wrapped distance is below ring size, so modular PTR_WIDTH arithmetic is exact.
    assign w_wptr     = rx_ring_wptr[c*PTR_WIDTH +: PTR_WIDTH];
    assign w_raw      = (w_wptr >= r_msi_ptr) ? (w_wptr - r_msi_ptr)
                                              : (w_wptr + rx_ring_size - r_msi_ptr);
    assign w_pend[c]  = w_raw & {{(PTR_WIDTH-2){1'b1}}, 2'b00};
    assign w_ack_here = w_ack && (r_upd_chan == CHAN_W'(c));
    assign w_idle_hit = (irq_timeout != '0) && (r_timer >= irq_timeout) && (w_pend[c] != '0);
    assign w_trig[c]  = chan_enable[c] && ((w_pend[c] >= rx_block_size) || w_idle_hit);
    assign w_sum      = {1'b0, r_msi_ptr} + {1'b0, r_upd_bytes};
    assign w_adv      = (w_sum >= {1'b0, rx_ring_size}) ? PTR_WIDTH'(w_sum - {1'b0, rx_ring_size})
                                                        : w_sum[PTR_WIDTH-1:0];

    // Per-channel consumed pointer and idle timer; a disabled channel shadows its wptr.
    always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
        r_msi_ptr <= '0;
        r_timer   <= '0;
      end else if (init) begin
        r_msi_ptr <= '0;
        r_timer   <= '0;
      end else begin
        if (!chan_enable[c]) begin
          r_msi_ptr <= w_wptr;
        end else if (w_ack_here) begin
          r_msi_ptr <= w_adv;
        end
        if (!chan_enable[c] || (w_pend[c] == '0) || w_ack_here) begin
          r_timer <= '0;
        end else if (r_timer != '1) begin
          r_timer <= r_timer + TIMER_WIDTH'(1);
        end
      end
    end
  end

  // Only channels whose trigger is both registered and still live may be granted.
  assign w_req = r_irq_pending & w_trig;

  // Round-robin search from r_rr_ptr; descending loop lets the nearest requester win.
  always_comb begin
    logic [CHAN_W:0]   v_sum;
    logic [CHAN_W-1:0] v_idx;
    v_sum         = '0;
    v_idx         = '0;
    w_grant_valid = 1'b0;
    w_grant_chan  = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      v_sum         = {1'b0, r_rr_ptr} + (CHAN_W+1)'(i);
      v_idx         = (v_sum >= (CHAN_W+1)'(NUM_CHAN)) ? CHAN_W'(v_sum - (CHAN_W+1)'(NUM_CHAN))
                                                       : v_sum[CHAN_W-1:0];
      w_grant_chan  = w_req[v_idx] ? v_idx : w_grant_chan;
      w_grant_valid = w_grant_valid | w_req[v_idx];
    end
  end

  assign w_rr_next = (w_grant_chan == CHAN_W'(NUM_CHAN - 1)) ? '0 : (w_grant_chan + CHAN_W'(1));

  // Next-state logic for the event handshake sequence.
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_next = ST_UPD;
          w_take = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_UPD: begin
        if (upd_ack) begin
          w_next = (USE_MSI && irq_enable) ? ST_MSI_WAIT : ST_IDLE;
        end else begin
          w_next = ST_UPD;
        end
      end
      ST_MSI_WAIT: begin
        if (msi_sel) begin
          w_next = ST_MSI_REQ;
        end else begin
          w_next = ST_MSI_WAIT;
        end
      end
      ST_MSI_REQ: begin
        if (app_msi_ack) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_MSI_REQ;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, registered handshake outputs, latched event and round-robin pointer.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_upd_req     <= 1'b0;
      r_msi_ready   <= 1'b0;
      r_app_msi_req <= 1'b0;
      r_upd_chan    <= '0;
      r_upd_bytes   <= '0;
      r_rr_ptr      <= '0;
      r_irq_pending <= '0;
    end else if (init) begin
      r_state       <= ST_IDLE;
      r_upd_req     <= 1'b0;
      r_msi_ready   <= 1'b0;
      r_app_msi_req <= 1'b0;
      r_upd_chan    <= '0;
      r_upd_bytes   <= '0;
      r_rr_ptr      <= '0;
      r_irq_pending <= '0;
    end else begin
      r_state       <= w_next;
      r_upd_req     <= (w_next == ST_UPD);
      r_msi_ready   <= (w_next == ST_MSI_WAIT);
      r_app_msi_req <= (w_next == ST_MSI_REQ);
      r_irq_pending <= w_trig;
      if (w_take) begin
        r_upd_chan  <= w_grant_chan;
        r_upd_bytes <= w_pend[w_grant_chan];
        r_rr_ptr    <= w_rr_next;
      end
    end
  end

  assign upd_req     = r_upd_req;
  assign upd_chan    = r_upd_chan;
  assign upd_bytes   = r_upd_bytes;
  assign msi_ready   = r_msi_ready;
  assign app_msi_req = r_app_msi_req;
  assign app_msi_num = 5'(r_upd_chan);
  assign irq_pending = r_irq_pending;

endmodule

// File: tb/tb_sonic_irq_coalescer.sv
`timescale 1ns/1ps
// Directed self-checking bench for sonic_irq_coalescer (2 channels, 4 KiB rings).
module tb_sonic_irq_coalescer;
  localparam int NC = 2;
  localparam int PW = 13;
  localparam int TW = 16;

  logic            clk_in = 1'b0;
  logic            rstn, init, irq_enable;
  logic [NC-1:0]   chan_enable;
  logic [PW-1:0]   rx_ring_size, rx_block_size;
  logic [TW-1:0]   irq_timeout;
  logic [NC*PW-1:0] rx_ring_wptr;
  logic            upd_req, upd_ack, msi_ready, msi_sel, app_msi_req, app_msi_ack;
  logic [0:0]      upd_chan;
  logic [PW-1:0]   upd_bytes;
  logic [4:0]      app_msi_num;
  logic [NC-1:0]   irq_pending;

  int n_tests = 0;
  int n_fail  = 0;

  sonic_irq_coalescer #(.NUM_CHAN(NC), .PTR_WIDTH(PW), .TIMER_WIDTH(TW), .USE_MSI(1'b1)) dut (
    .clk_in(clk_in), .rstn(rstn), .init(init), .irq_enable(irq_enable),
    .chan_enable(chan_enable), .rx_ring_size(rx_ring_size), .rx_block_size(rx_block_size),
    .irq_timeout(irq_timeout), .rx_ring_wptr(rx_ring_wptr),
    .upd_req(upd_req), .upd_ack(upd_ack), .upd_chan(upd_chan), .upd_bytes(upd_bytes),
    .msi_ready(msi_ready), .msi_sel(msi_sel), .app_msi_req(app_msi_req),
    .app_msi_ack(app_msi_ack), .app_msi_num(app_msi_num), .irq_pending(irq_pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_wptr(input int ch, input int val);
    rx_ring_wptr[ch*PW +: PW] = PW'(val);
  endtask

  task automatic wait_upd(input string tag, input int chan, input int bytes);
    int k;
    k = 0;
    while (!upd_req && k < 200) begin
      step(1);
      k++;
    end
    check({tag, " upd_req"}, upd_req, 1);
    check({tag, " upd_chan"}, upd_chan, chan);
    check({tag, " upd_bytes"}, upd_bytes, bytes);
  endtask

  task automatic ack_upd(input string tag);
    upd_ack = 1'b1;
    step(1);
    upd_ack = 1'b0;
    check({tag, " upd_req drop"}, upd_req, 0);
  endtask

  task automatic msi_phase(input string tag, input int chan);
    check({tag, " msi_ready"}, msi_ready, 1);
    msi_sel = 1'b1;
    step(1);
    msi_sel = 1'b0;
    check({tag, " app_msi_req"}, app_msi_req, 1);
    check({tag, " msi_ready drop"}, msi_ready, 0);
    check({tag, " app_msi_num"}, app_msi_num, chan);
    step(2);
    check({tag, " app_msi_req held"}, app_msi_req, 1);
    app_msi_ack = 1'b1;
    step(1);
    app_msi_ack = 1'b0;
    check({tag, " app_msi_req drop"}, app_msi_req, 0);
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      step(1);
      seen = seen | upd_req | msi_ready | app_msi_req;
    end
    check({tag, " quiet"}, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rstn = 1'b0; init = 1'b0; irq_enable = 1'b1; chan_enable = 2'b11;
    rx_ring_size = 13'd4096; rx_block_size = 13'd256; irq_timeout = '0;
    rx_ring_wptr = '0; upd_ack = 1'b0; msi_sel = 1'b0; app_msi_ack = 1'b0;
    step(2);
    check("rst upd_req", upd_req, 0);
    check("rst msi_ready", msi_ready, 0);
    check("rst app_msi_req", app_msi_req, 0);
    check("rst irq_pending", irq_pending, 0);
    check("rst upd_bytes", upd_bytes, 0);
    check("rst app_msi_num", app_msi_num, 0);
    rstn = 1'b1;
    step(2);

    // Basic threshold event on ch0 with latency check
    set_wptr(0, 256);
    for (int k = 0; k < 5 && !irq_pending[0]; k++) step(1);
    check("basic irq_pending", irq_pending, 2'b01);
    check("basic latency upd_req low", upd_req, 0);
    step(1);
    wait_upd("basic", 0, 256);
    ack_upd("basic");
    msi_phase("basic", 0);
    check("basic irq_pending clear", irq_pending, 0);

    // Ring wrap with MSI disabled: status update only
    irq_enable = 1'b0;
    set_wptr(0, 3968);
    wait_upd("pre-wrap", 0, 3712);
    ack_upd("pre-wrap");
    quiet("pre-wrap no msi", 3);
    set_wptr(0, 128);
    wait_upd("wrap", 0, 256);
    ack_upd("wrap");
    quiet("wrap no msi", 3);
    set_wptr(0, 384);
    wait_upd("post-wrap ptr128", 0, 256);
    ack_upd("post-wrap");
    quiet("post-wrap no msi", 3);

    // Just below threshold after 4-byte alignment, then exactly at it
    set_wptr(0, 639);
    quiet("below block", 8);
    check("below block irq_pending", irq_pending, 0);
    set_wptr(0, 640);
    wait_upd("at block", 0, 256);
    ack_upd("at block");
    quiet("at block no msi", 2);
    irq_enable = 1'b1;

    // Idle timeout on a partial fill
    irq_timeout = 16'd100;
    set_wptr(0, 704);
    seen = 1'b0;
    repeat (99) begin
      step(1);
      seen = seen | upd_req;
    end
    check("timeout early", seen, 0);
    wait_upd("timeout", 0, 64);
    ack_upd("timeout");
    msi_phase("timeout", 0);
    irq_timeout = '0;

    // init while the MSI request is outstanding
    set_wptr(0, 960);
    wait_upd("init ev", 0, 256);
    ack_upd("init ev");
    check("init msi_ready", msi_ready, 1);
    msi_sel = 1'b1;
    step(1);
    msi_sel = 1'b0;
    check("init app_msi_req up", app_msi_req, 1);
    init = 1'b1;
    rx_ring_wptr = '0;
    step(1);
    init = 1'b0;
    check("init app_msi_req drop", app_msi_req, 0);
    check("init upd_req", upd_req, 0);
    check("init msi_ready", msi_ready, 0);
    check("init irq_pending", irq_pending, 0);
    quiet("after init", 10);

    // Both channels pending: grants alternate from ch0; wptr moves in the ack cycle
    set_wptr(0, 256);
    set_wptr(1, 256);
    wait_upd("rr0", 0, 256);
    upd_ack = 1'b1;
    set_wptr(0, 512);
    step(1);
    upd_ack = 1'b0;
    check("rr0 upd_req drop", upd_req, 0);
    msi_phase("rr0", 0);
    wait_upd("rr1", 1, 256);
    ack_upd("rr1");
    set_wptr(1, 512);
    msi_phase("rr1", 1);
    wait_upd("rr2", 0, 256);
    ack_upd("rr2");
    msi_phase("rr2", 0);
    wait_upd("rr3", 1, 256);
    ack_upd("rr3");
    msi_phase("rr3", 1);

    // Disabled channel with a moving wptr, then re-enable without a stale burst
    chan_enable = 2'b01;
    set_wptr(1, 1000);
    quiet("dis a", 3);
    set_wptr(1, 3000);
    quiet("dis b", 3);
    set_wptr(1, 100);
    quiet("dis c", 3);
    check("dis irq_pending", irq_pending, 0);
    chan_enable = 2'b11;
    quiet("reenable", 8);
    set_wptr(1, 356);
    wait_upd("reenable ev", 1, 256);
    ack_upd("reenable ev");
    msi_phase("reenable ev", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
